// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: turns a committing instruction's fault flags into
// a CP0 update, a multi-cycle pipeline flush and a fetch redirect.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic [6:0]  commit_exc,
    input  logic        commit_eret,
    input  logic [31:0] commit_vaddr,
    input  logic [5:0]  hardware_int,
    input  logic [1:0]  soft_int,
    input  logic [7:0]  int_mask,
    input  logic        is_ie,
    input  logic        is_exl,
    input  logic [31:0] errorpc,
    output logic        is_exception,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        is_bd,
    output logic        we_badvaddr,
    output logic [31:0] badvaddr,
    output logic        is_excep_return,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0c;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        FLUSH,
        REDIRECT
    } state_t;

    state_t state_q, state_d;

    logic        int_pend_q;
    logic [3:0]  cnt_q;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        bd_q;
    logic [31:0] vaddr_q;
    logic        bad_q;
    logic        eret_q;
    logic [31:0] target_q;

    logic        accept;
    logic        ev_trap;
    logic        ev_eret;
    logic [4:0]  ev_code;
    logic        ev_bad;
    logic [31:0] ev_vaddr;

    logic adel_if, ri, ov, sys, bp, adel_d, ades;

    assign {adel_if, ri, ov, sys, bp, adel_d, ades} = commit_exc;

    assign commit_ready = rst & (state_q == IDLE);
    assign accept       = commit_valid & commit_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            int_pend_q <= 1'b0;
        end else begin
            int_pend_q <= (|({hardware_int, soft_int} & int_mask))
                        & is_ie & ~is_exl;
        end
    end

    // Winning event among the interrupt, the fault flags and ERET.
    always_comb begin
        ev_trap  = 1'b1;
        ev_eret  = 1'b0;
        ev_code  = CODE_INT;
        ev_bad   = 1'b0;
        ev_vaddr = 32'd0;
        priority case (1'b1)
            int_pend_q: ev_code = CODE_INT;
            adel_if: begin
                ev_code  = CODE_ADEL;
                ev_bad   = 1'b1;
                ev_vaddr = commit_pc;
            end
            ri:  ev_code = CODE_RI;
            ov:  ev_code = CODE_OV;
            sys: ev_code = CODE_SYS;
            bp:  ev_code = CODE_BP;
            adel_d: begin
                ev_code  = CODE_ADEL;
                ev_bad   = 1'b1;
                ev_vaddr = commit_vaddr;
            end
            ades: begin
                ev_code  = CODE_ADES;
                ev_bad   = 1'b1;
                ev_vaddr = commit_vaddr;
            end
            commit_eret: begin
                ev_trap = 1'b0;
                ev_eret = 1'b1;
            end
            default: ev_trap = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            code_q  <= 5'd0;
            pc_q    <= 32'd0;
            bd_q    <= 1'b0;
            vaddr_q <= 32'd0;
            bad_q   <= 1'b0;
            eret_q  <= 1'b0;
        end else if (accept && (ev_trap || ev_eret)) begin
            code_q  <= ev_code;
            pc_q    <= commit_pc;
            bd_q    <= commit_bd;
            vaddr_q <= ev_vaddr;
            bad_q   <= ev_bad;
            eret_q  <= ev_eret;
        end
    end

    // Redirect target is captured in TRAP so ERET sees the CP0 value of that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            target_q <= 32'd0;
        end else if (state_q == TRAP) begin
            target_q <= eret_q ? errorpc : EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            if (state_q == FLUSH && state_d == FLUSH) begin
                cnt_q <= cnt_q + 4'd1;
            end else begin
                cnt_q <= 4'd0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (ev_trap || ev_eret)) begin
                    state_d = TRAP;
                end
            end
            TRAP: state_d = FLUSH;
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_exception    = 1'b0;
        exc_code        = 5'd0;
        exc_pc          = 32'd0;
        is_bd           = 1'b0;
        we_badvaddr     = 1'b0;
        badvaddr        = 32'd0;
        is_excep_return = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'd0;
        unique case (state_q)
            TRAP: begin
                flush = 1'b1;
                if (eret_q) begin
                    is_excep_return = 1'b1;
                end else begin
                    is_exception = 1'b1;
                    exc_code     = code_q;
                    exc_pc       = bd_q ? pc_q - 32'd4 : pc_q;
                    is_bd        = bd_q;
                    we_badvaddr  = bad_q;
                    badvaddr     = bad_q ? vaddr_q : 32'd0;
                end
            end
            FLUSH: flush = 1'b1;
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected CP0/redirect records queued at commit,
// popped and compared when the trap pulse appears.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, commit_ready;
    logic [31:0] commit_pc, commit_vaddr, errorpc;
    logic        commit_bd, commit_eret;
    logic [6:0]  commit_exc;
    logic [5:0]  hardware_int;
    logic [1:0]  soft_int;
    logic [7:0]  int_mask;
    logic        is_ie, is_exl;
    logic        is_exception, is_bd, we_badvaddr, is_excep_return;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, badvaddr, redirect_pc;
    logic        flush, redirect_valid, redirect_ready;

    typedef struct {
        logic        exc;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        we;
        logic [31:0] bva;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_bd(commit_bd),
        .commit_exc(commit_exc), .commit_eret(commit_eret),
        .commit_vaddr(commit_vaddr),
        .hardware_int(hardware_int), .soft_int(soft_int),
        .int_mask(int_mask), .is_ie(is_ie), .is_exl(is_exl),
        .errorpc(errorpc),
        .is_exception(is_exception), .exc_code(exc_code),
        .exc_pc(exc_pc), .is_bd(is_bd), .we_badvaddr(we_badvaddr),
        .badvaddr(badvaddr), .is_excep_return(is_excep_return),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic exc, input logic eret,
                                input logic [4:0] code, input logic [31:0] epc,
                                input logic bd, input logic we,
                                input logic [31:0] bva, input logic [31:0] rpc);
        exp_t e;
        e.exc = exc; e.eret = eret; e.code = code; e.epc = epc;
        e.bd = bd; e.we = we; e.bva = bva; e.rpc = rpc;
        return e;
    endfunction

    task automatic commit(input logic [31:0] pc, input logic bd,
                          input logic [6:0] exc, input logic eret,
                          input logic [31:0] va);
        @(negedge clk);
        commit_pc    = pc;
        commit_bd    = bd;
        commit_exc   = exc;
        commit_eret  = eret;
        commit_vaddr = va;
        commit_valid = 1'b1;
        chk("commit_ready", commit_ready, 1);
        @(negedge clk);
        commit_valid = 1'b0;
        commit_exc   = '0;
        commit_eret  = 1'b0;
        commit_bd    = 1'b0;
    endtask

    // Called at the negedge right after the accept edge.
    task automatic observe(input string tag, input int hold);
        exp_t e;
        int n, f, p;
        n = 0;
        while (!(is_exception || is_excep_return) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, 32'(is_exception | is_excep_return), 1);
        e = sb.pop_front();
        chk({tag, "_exc"}, 32'(is_exception), 32'(e.exc));
        chk({tag, "_eret"}, 32'(is_excep_return), 32'(e.eret));
        chk({tag, "_code"}, 32'(exc_code), 32'(e.code));
        chk({tag, "_epc"}, exc_pc, e.epc);
        chk({tag, "_bd"}, 32'(is_bd), 32'(e.bd));
        chk({tag, "_we"}, 32'(we_badvaddr), 32'(e.we));
        chk({tag, "_bva"}, badvaddr, e.bva);
        f = 0;
        p = 0;
        while (!redirect_valid && f < 20) begin
            if (flush) f++;
            if (is_exception || is_excep_return) p++;
            @(negedge clk);
        end
        chk({tag, "_flush_cyc"}, 32'(f), 32'(FC + 1));
        chk({tag, "_pulses"}, 32'(p), 1);
        chk({tag, "_rpc"}, redirect_pc, e.rpc);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_rv_hold"}, 32'(redirect_valid), 1);
            chk({tag, "_rpc_hold"}, redirect_pc, e.rpc);
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        chk({tag, "_idle_rdy"}, 32'(commit_ready), 1);
        chk({tag, "_idle_rv"}, 32'(redirect_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        commit_valid = 1'b0;
        commit_pc = '0; commit_vaddr = '0; commit_bd = 1'b0;
        commit_exc = '0; commit_eret = 1'b0;
        hardware_int = '0; soft_int = '0; int_mask = '0;
        is_ie = 1'b0; is_exl = 1'b0;
        errorpc = '0;
        redirect_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_exc", 32'(is_exception), 0);
        chk("rst_rv", 32'(redirect_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(commit_ready), 1);

        // overflow, not in delay slot
        sb.push_back(mk(1, 0, 5'h0c, 32'h8000_0100, 0, 0, 0, VEC));
        commit(32'h8000_0100, 0, 7'b0010000, 0, 0);
        observe("ov", 0);

        // store address error in delay slot
        sb.push_back(mk(1, 0, 5'h05, 32'h8000_0200, 1, 1, 32'h0000_1003, VEC));
        commit(32'h8000_0204, 1, 7'b0000001, 0, 32'h0000_1003);
        observe("ades", 1);

        // fetch address error reports the PC as bad address
        sb.push_back(mk(1, 0, 5'h04, 32'h8000_0003, 0, 1, 32'h8000_0003, VEC));
        commit(32'h8000_0003, 0, 7'b1000000, 0, 32'h1234_5678);
        observe("adelif", 0);

        // ri beats ov
        sb.push_back(mk(1, 0, 5'h0a, 32'h8000_0010, 0, 0, 0, VEC));
        commit(32'h8000_0010, 0, 7'b0110000, 0, 0);
        observe("ri", 0);

        // bp beats eret
        sb.push_back(mk(1, 0, 5'h09, 32'h8000_0020, 0, 0, 0, VEC));
        commit(32'h8000_0020, 0, 7'b0000100, 1, 0);
        observe("bp_eret", 0);

        // pending interrupt alone never starts a trap
        hardware_int = 6'b000001; int_mask = 8'h04; is_ie = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("int_idle_flush", 32'(flush), 0);
            chk("int_idle_rdy", 32'(commit_ready), 1);
        end

        // interrupt beats sys
        sb.push_back(mk(1, 0, 5'h00, 32'h8000_0030, 0, 0, 0, VEC));
        commit(32'h8000_0030, 0, 7'b0001000, 0, 0);
        observe("int_sys", 0);

        // interrupt on a delay-slot instruction
        sb.push_back(mk(1, 0, 5'h00, 32'h8000_0040, 1, 0, 0, VEC));
        commit(32'h8000_0044, 1, 7'b0000000, 0, 0);
        hardware_int = '0;
        observe("int_bd", 0);
        @(negedge clk);

        // eret with redirect back-pressure
        errorpc = 32'h8000_0400;
        sb.push_back(mk(0, 1, 5'h00, 32'h0, 0, 0, 0, 32'h8000_0400));
        commit(32'h8000_0050, 0, 7'b0000000, 1, 0);
        observe("eret", 5);

        // plain instruction: no event
        commit(32'h8000_0060, 0, 7'b0000000, 0, 0);
        chk("none_flush", 32'(flush), 0);
        chk("none_rdy", 32'(commit_ready), 1);

        // reset during FLUSH aborts the sequence
        commit(32'h8000_0070, 0, 7'b0010000, 0, 0);
        chk("abort_trap", 32'(is_exception), 1);
        @(negedge clk);
        chk("abort_in_flush", 32'(flush), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_flush", 32'(flush), 0);
        chk("abort_rv", 32'(redirect_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rdy", 32'(commit_ready), 1);
        repeat (4) begin
            @(negedge clk);
            chk("abort_quiet", 32'(flush | redirect_valid | is_exception), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC0_0380: general exception entry PC.
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles the FLUSH state holds pipeline flush; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 commit_valid  in  1  commit stage presents an instruction; commit_ready  out  1  controller accepts it.
REQ-006 commit_pc  in  32  PC of the committing instruction; commit_bd  in  1  instruction sits in a delay slot.
REQ-007 commit_exc  in  7  flags {adel_if, ri, ov, sys, bp, adel_d, ades}; commit_eret  in  1  ERET commits; commit_vaddr  in  32  data address for adel_d/ades.
REQ-008 hardware_int  in  6; soft_int  in  2; int_mask  in  8; is_ie  in  1; is_exl  in  1; errorpc  in  32: CP0 state.
REQ-009 is_exception  out  1; exc_code  out  5; exc_pc  out  32; is_bd  out  1; we_badvaddr  out  1; badvaddr  out  32; is_excep_return  out  1: CP0 update port.
REQ-010 flush  out  1  kill all in-flight pipeline stages.
REQ-011 redirect_valid  out  1; redirect_pc  out  32; redirect_ready  in  1: fetch redirect handshake.

Function
REQ-012 int_pend_q SHALL register (|({hardware_int,soft_int} & int_mask)) & is_ie & ~is_exl every cycle.
REQ-013 Accept SHALL occur when commit_valid & commit_ready; commit_ready SHALL be 1 only in state IDLE.
REQ-014 Accepted event priority, highest first: interrupt (int_pend_q, code 5'h00), adel_if (5'h04), ri (5'h0a), ov (5'h0c), sys (5'h08), bp (5'h09), adel_d (5'h04), ades (5'h05), eret; no flags -> no event, remain IDLE.
REQ-015 An event SHALL latch code, pc, bd, vaddr and kind (trap/eret) in registers on the accept edge.
REQ-016 FSM states IDLE, TRAP, FLUSH, REDIRECT; IDLE->TRAP on accepted event; TRAP->FLUSH unconditionally; FLUSH->REDIRECT when flush counter reaches FLUSH_CYCLES-1; REDIRECT->IDLE when redirect_ready.
REQ-017 In TRAP, trap kind: is_exception=1 for exactly one cycle with exc_code=latched code, is_bd=latched bd, exc_pc = bd ? pc-32'd4 : pc (modulo 2^32).
REQ-018 In TRAP, we_badvaddr=1 only for adel_if (badvaddr=pc) or adel_d/ades (badvaddr=vaddr); otherwise 0.
REQ-019 In TRAP, eret kind: is_excep_return=1 for exactly one cycle; is_exception=0.
REQ-020 flush SHALL be 1 in TRAP and every FLUSH cycle; 0 otherwise.
REQ-021 In REDIRECT, redirect_valid=1 and redirect_pc SHALL hold EXC_VECTOR (trap) or errorpc sampled in TRAP (eret), stable until redirect_ready.
REQ-022 Event arriving with commit_bd and interrupt SHALL report is_bd=1, exc_pc=pc-4.
REQ-023 Simultaneous eret and any exception flag: exception wins, no is_excep_return.
REQ-024 commit_valid low while in IDLE: no state change; int_pend_q alone SHALL NOT start a trap.
REQ-025 All CP0-port outputs SHALL be 0 outside TRAP.

Reset
REQ-026 rst low at a clock edge: state IDLE, flush counter 0, int_pend_q 0, latched fields 0, all outputs 0 except commit_ready=1 on the first cycle after release.
REQ-027 Reset asserted in any state SHALL abort the sequence with no further is_exception, flush or redirect pulses.

Verification
REQ-028 pc=32'h8000_0100, ov=1, bd=0 -> TRAP: is_exception=1, exc_code=5'h0c, exc_pc=32'h8000_0100, we_badvaddr=0; flush 3 cycles; redirect_pc=32'hBFC0_0380.
REQ-029 pc=32'h8000_0204, bd=1, ades=1, vaddr=32'h0000_1003 -> exc_code=5'h05, exc_pc=32'h8000_0200, is_bd=1, we_badvaddr=1, badvaddr=32'h0000_1003.
REQ-030 hardware_int[0]=1, int_mask=8'h04, is_ie=1, is_exl=0, one cycle later commit sys=1 -> exc_code=5'h00 (interrupt beats sys).
REQ-031 eret=1 with errorpc=32'h8000_0400, redirect_ready low 5 cycles -> is_excep_return one cycle, redirect_valid held 5+ cycles, redirect_pc=32'h8000_0400, then IDLE.
REQ-032 eret=1 and bp=1 together -> exc_code=5'h09, is_excep_return=0.
REQ-033 rst low during FLUSH -> next cycle flush=0, redirect_valid=0, commit_ready=1 after release.
